// File: rtl/efifo_key_sched.sv
// ----------------------------------------------------------------------------
// efifo_key_sched
//   Key-rotation controller for the 128-bit XOR-encrypted FIFO. Encrypt and
//   decrypt share one key, so the key may only change once the FIFO holds no
//   words written under the old key. On a rotation request the block gates
//   producer writes, waits for the FIFO to drain, holds a settle window so
//   the consumer can sample the last output, then swaps the key atomically.
//
// Parameters
//   KEY_RESET      value of active_key_o after reset
//   SETTLE_CYCLES  cycles held in SETTLE after the FIFO reports empty (>=1)
//   DRAIN_TIMEOUT  DRAIN cycles allowed before the rotation aborts (>=1)
//   EPOCH_W        width of the completed-rotation counter
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   key_in         new key, captured when key_load is seen in IDLE
//   key_load       rotation request, level-sampled; ignored outside IDLE
//   key_busy_o     high in every state except IDLE
//   key_done_o     one-cycle pulse in the first cycle the new key is active
//   key_err_o      one-cycle pulse after a rotation aborted on drain timeout
//   active_key_o   key driven to the FIFO secret_key input
//   key_epoch_o    number of completed rotations, wraps
//   wr_req_i       producer write request
//   wr_ready_o     producer may write this cycle (combinational)
//   wr_en_o        write strobe to the FIFO (combinational)
//   fifo_full_i    FIFO full flag
//   fifo_empty_i   FIFO empty flag
// ----------------------------------------------------------------------------
module efifo_key_sched #(
    parameter logic [127:0] KEY_RESET     = '0,
    parameter int unsigned  SETTLE_CYCLES = 2,
    parameter int unsigned  DRAIN_TIMEOUT = 1024,
    parameter int unsigned  EPOCH_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [127:0]       key_in,
    input  logic               key_load,
    output logic               key_busy_o,
    output logic               key_done_o,
    output logic               key_err_o,
    output logic [127:0]       active_key_o,
    output logic [EPOCH_W-1:0] key_epoch_o,
    input  logic               wr_req_i,
    output logic               wr_ready_o,
    output logic               wr_en_o,
    input  logic               fifo_full_i,
    input  logic               fifo_empty_i
);

    localparam int unsigned DCW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam int unsigned SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    // Terminal counts: the drain counter starts at 0 on entry, so the
    // DRAIN_TIMEOUT-th DRAIN cycle is the one that sees DRAIN_LAST. The settle
    // counter counts down from SETTLE_LOAD and leaves SETTLE when it reads 0.
    localparam logic [DCW-1:0] DRAIN_LAST  = DCW'(DRAIN_TIMEOUT - 1);
    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2,
        SWAP   = 2'd3
    } state_t;

    state_t             state_q,      state_d;
    logic [127:0]       active_key_q, active_key_d;
    logic [127:0]       pending_q,    pending_d;
    logic [EPOCH_W-1:0] epoch_q,      epoch_d;
    logic               done_q,       done_d;
    logic               err_q,        err_d;
    logic [DCW-1:0]     drain_cnt_q,  drain_cnt_d;
    logic [SCW-1:0]     settle_cnt_q, settle_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            active_key_q <= KEY_RESET;
            pending_q    <= '0;
            epoch_q      <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            drain_cnt_q  <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            active_key_q <= active_key_d;
            pending_q    <= pending_d;
            epoch_q      <= epoch_d;
            done_q       <= done_d;
            err_q        <= err_d;
            drain_cnt_q  <= drain_cnt_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        active_key_d = active_key_q;
        pending_d    = pending_q;
        epoch_d      = epoch_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        drain_cnt_d  = drain_cnt_q;
        settle_cnt_d = settle_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (key_load) begin
                    pending_d   = key_in;
                    drain_cnt_d = '0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                // Empty takes priority over a timeout landing in the same cycle.
                if (fifo_empty_i) begin
                    settle_cnt_d = SETTLE_LOAD;
                    state_d      = SETTLE;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    pending_d = '0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            SETTLE: begin
                // Writes are blocked, so empty cannot change here.
                if (settle_cnt_q == '0) begin
                    state_d = SWAP;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end
            SWAP: begin
                active_key_d = pending_q;
                epoch_d      = epoch_q + 1'b1;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign key_busy_o   = (state_q != IDLE);
    assign key_done_o   = done_q;
    assign key_err_o    = err_q;
    assign active_key_o = active_key_q;
    assign key_epoch_o  = epoch_q;
    assign wr_ready_o   = (state_q == IDLE) && !fifo_full_i;
    assign wr_en_o      = wr_req_i && wr_ready_o;

endmodule
